// File: rtl/copy_engine_pkg.sv
// Shared types and result codes for the Wishbone block-copy engine.
package copy_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BUSERR  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

endpackage

// File: rtl/wb_master_port.sv
// Runs one Wishbone classic read or write with timeout and abort; the response is registered
// so the bus is always idle for the cycle in which the sequencer sees it.
module wb_master_port
  import copy_engine_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_adr_i,
  input  logic [DW-1:0] req_dat_i,
  input  logic          abort_i,
  output logic          rsp_valid_o,
  output logic [1:0]    rsp_code_o,
  output logic          rsp_ack_o,
  output logic [DW-1:0] rdata_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic          cyc_q, cyc_d, we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d, rdata_q, rdata_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_ack_q, rsp_ack_d;
  logic [1:0]    rsp_code_q, rsp_code_d;

  always_comb begin
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rdata_d     = rdata_q;
    tmo_d       = tmo_q;
    rsp_valid_d = 1'b0;
    rsp_ack_d   = 1'b0;
    rsp_code_d  = rsp_code_q;
    if (cyc_q) begin
      // err beats ack; an ack that coincides with abort still completes the transfer
      if (wb_err_i) begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_code_d  = ST_BUSERR;
      end else if (wb_ack_i) begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_ack_d   = 1'b1;
        rsp_code_d  = abort_i ? ST_ABORT : ST_OK;
        if (!we_q) rdata_d = wb_dat_i;
      end else if (abort_i) begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_code_d  = ST_ABORT;
      end else if (tmo_q == '0) begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_code_d  = ST_TIMEOUT;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end else if (req_i) begin
      cyc_d = 1'b1;
      we_d  = req_we_i;
      adr_d = req_adr_i;
      dat_d = req_dat_i;
      tmo_d = TW'(TIMEOUT - 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rdata_q     <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ack_q   <= 1'b0;
      rsp_code_q  <= ST_OK;
    end else begin
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rdata_q     <= rdata_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ack_q   <= rsp_ack_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_ack_o   = rsp_ack_q;
  assign rsp_code_o  = rsp_code_q;
  assign rdata_o     = rdata_q;

endmodule

// File: rtl/wb_copy_engine.sv
// Wishbone block-copy master: sequences read/write word pairs through wb_master_port.
// Command handshake: a command transfers on the clock edge where cmd_valid && cmd_ready.
module wb_copy_engine
  import copy_engine_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int LW      = 12,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_ni,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_src,
  input  logic [AW-1:0]   cmd_dst,
  input  logic [LW-1:0]   cmd_len,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [1:0]      status,
  output logic [LW-1:0]   words_done,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  output state_e          dbg_state_o
);

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] len_q, len_d, words_q, words_d;
  logic [1:0]    status_q, status_d;
  logic          done_q, busy_q, ready_q;

  logic          req, req_we, rsp_valid, rsp_ack;
  logic [AW-1:0] req_adr;
  logic [1:0]    rsp_code;
  logic [DW-1:0] rdata;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    words_d  = words_q;
    status_d = status_q;
    req      = 1'b0;
    req_we   = 1'b0;
    req_adr  = src_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          src_d    = cmd_src;
          dst_d    = cmd_dst;
          len_d    = cmd_len;
          words_d  = '0;
          status_d = ST_OK;
          if (cmd_len == '0) begin
            state_d = FIN;
          end else begin
            state_d = RD;
            req     = 1'b1;
            req_adr = cmd_src;
          end
        end
      end
      RD: begin
        if (rsp_valid) begin
          if (rsp_code != ST_OK) begin
            status_d = rsp_code;
            state_d  = FIN;
          end else if (abort) begin
            status_d = ST_ABORT;
            state_d  = FIN;
          end else begin
            req     = 1'b1;
            req_we  = 1'b1;
            req_adr = dst_q;
            state_d = WR;
          end
        end
      end
      WR: begin
        if (rsp_valid) begin
          // an acknowledged write counts even when abort arrived with it
          if (rsp_ack) begin
            words_d = words_q + 1'b1;
            src_d   = src_q + 1'b1;
            dst_d   = dst_q + 1'b1;
            len_d   = len_q - 1'b1;
          end
          if (rsp_code != ST_OK) begin
            status_d = rsp_code;
            state_d  = FIN;
          end else if (abort) begin
            status_d = ST_ABORT;
            state_d  = FIN;
          end else if (len_q == LW'(1)) begin
            state_d = FIN;
          end else begin
            req     = 1'b1;
            req_adr = src_q + 1'b1;
            state_d = RD;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      words_q  <= '0;
      status_q <= ST_OK;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      words_q  <= words_d;
      status_q <= status_d;
      done_q   <= (state_d == FIN);
      busy_q   <= (state_d != IDLE);
      ready_q  <= (state_d == IDLE);
    end
  end

  wb_master_port #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) u_port (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_reset_ni),
    .req_i      (req),
    .req_we_i   (req_we),
    .req_adr_i  (req_adr),
    .req_dat_i  (rdata),
    .abort_i    (abort),
    .rsp_valid_o(rsp_valid),
    .rsp_code_o (rsp_code),
    .rsp_ack_o  (rsp_ack),
    .rdata_o    (rdata),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  assign wb_sel_o    = '1;
  assign cmd_ready   = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign words_done  = words_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/wb_copy_engine.md
Name: wb_copy_engine

Overview:
- Wishbone classic (B3) bus master that copies a block of 32-bit words from a source address to a destination address, one word at a time.
- It is the initiator counterpart to the team's Wishbone slave peripherals (misc, USB serial). It attaches to a spare master port of the peripheral crossbar.
- A local command/status handshake drives it, normally from a wb_misc-style register slave.

Parameters:
- AW, 16, Wishbone word-address width; addresses increment by 1 per word.
- DW, 32, data width; wb_sel_o is DW/8 bits, always all-ones.
- LW, 12, length-counter width; maximum transfer is 2^LW-1 words.
- TIMEOUT, 255, cycles to wait for ack/err before aborting a bus cycle; must be ≥1.

Ports:
- wb_clk_i  in  1  system clock
- wb_reset_ni  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle and accepting a command
- cmd_src  in  AW  source word address
- cmd_dst  in  AW  destination word address
- cmd_len  in  LW  number of words to copy
- abort  in  1  request termination of the active copy
- busy  out  1  copy in progress
- done  out  1  one-cycle completion pulse
- status  out  2  result code: 0 OK, 1 bus error, 2 timeout, 3 aborted; held until next command
- words_done  out  LW  words fully written by the last or current copy
- wb_adr_o  out  AW  bus address
- wb_dat_o  out  DW  write data
- wb_dat_i  in  DW  read data
- wb_we_o  out  1  write enable
- wb_sel_o  out  DW/8  byte selects
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error

Behaviour:
- Reset values:
  - cmd_ready=1; busy=0; done=0; status=0; words_done=0.
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=all-ones.
- Command acceptance:
  - A command is accepted on the edge where cmd_valid & cmd_ready.
  - On acceptance, src, dst and len are latched; words_done and status clear to 0.
- FSM states: IDLE, RD, WR, FIN.
  - IDLE → RD on accept with len≠0.
  - IDLE → FIN on accept with len=0 (no bus cycles).
  - RD:
    - cyc=stb=1, we=0, adr=src.
    - On ack: capture wb_dat_i into the data register, drop cyc/stb for one cycle, → WR.
  - WR:
    - cyc=stb=1, we=1, adr=dst, dat=captured word.
    - On ack: words_done+1, src+1, dst+1, len-1.
    - If len reaches 0 → FIN; otherwise drop cyc/stb for one cycle and → RD.
  - FIN: done=1 for exactly one cycle, then → IDLE.
- Handshake rules:
  - All outputs are registered.
  - cyc and stb rise together and stay asserted with stable adr, we and dat until ack, err or timeout.
  - Each bus cycle is separated from the next by exactly one idle cycle (cyc=stb=0).
- Latency:
  - Accept to first stb: 1 cycle.
  - Per word: 2 bus cycles plus 2 idle cycles, plus slave wait states.
  - Zero-wait-state slave, N words: done asserts 4N+1 cycles after accept.
- Error handling:
  - wb_err_i in RD or WR → status=1, drop cyc/stb next cycle, → FIN.
  - Simultaneous ack and err: err wins.
  - Timeout counter reloads at each stb rise. Reaching TIMEOUT without ack/err → status=2, → FIN.
- Abort:
  - In IDLE, abort is ignored.
  - In RD or WR with no ack/err that cycle: drop cyc/stb next cycle, status=3, → FIN.
  - abort together with an ack in WR: the word counts, and status is still 3.
  - abort together with err: status=1.
- Address arithmetic: modulo 2^AW; 0xFFFF+1 wraps to 0x0000 silently.
- Outputs during FIN and IDLE:
  - busy=1 in RD/WR/FIN; cmd_ready=!busy.
  - cmd_valid during busy is ignored and not queued.
- Asynchronous reset mid-transfer:
  - cyc and stb drop immediately; all state returns to reset values.
  - The slave must tolerate a truncated cycle.

Decomposition:
- Package copy_engine_pkg:
  - state enum (IDLE, RD, WR, FIN);
  - status code localparams (ST_OK, ST_BUSERR, ST_TIMEOUT, ST_ABORT).
- Sub-module wb_master_port is natural: it runs a single Wishbone read or write with timeout.
  - Inputs: req, we, adr, dat, abort.
  - Outputs: rsp_valid, rsp_code, rdata.
- The top FSM sequences read/write pairs on top of wb_master_port.

Test Plan:
- Zero-wait slave memory preloaded with words 0x11111111..0x44444444 at 0x0100..0x0103; copy src=0x0100, dst=0x0200, len=4 → dst holds the same 4 words, done 17 cycles after accept, status=0, words_done=4.
- len=0 → no cyc assertion, done pulse 1 cycle after accept, status=0, words_done=0.
- Slave asserts err on the write of word 2 (len=5) → status=1, words_done=1, cyc low the cycle after err, done pulses once.
- Slave never acks, TIMEOUT=8 → first read's stb held 8 cycles, status=2, words_done=0; a subsequent normal command completes correctly.
- src=0xFFFE, len=3, 3-cycle slave wait states → reads from 0xFFFE, 0xFFFF, 0x0000; stb is held through each wait state with stable addr.
- Abort asserted mid-WR of word 3 (no ack) → status=3, words_done=2. A separate run drives abort coincident with the write ack: words_done=3, status=3.
